// File: rtl/muldiv_pkg.sv
// muldiv_pkg: RV32M funct3 encodings, FSM states and operand signedness helpers
package muldiv_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;
   function automatic logic signed_a(input logic [2:0] f);
      return f inside {F_MULH, F_MULHSU, F_DIV, F_REM};
   endfunction
   function automatic logic signed_b(input logic [2:0] f);
      return f inside {F_MULH, F_DIV, F_REM};
   endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV32M multiply/divide on magnitudes sharing one 2*XLEN shift register
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d, mul_step, div_step, prod;
   logic [2:0]        f_q, f_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d, res_q;
   logic [XLEN-1:0]   in_mag, b_mag, hi, lo, q_val, r_val, fin;
   logic [XLEN:0]     sum, rs, diff;
   logic              busy_q, done_q, neg_a, neg_b, div0, ovf;
   assign in_mag = (signed_a(funct3) & op1[XLEN-1]) ? -op1 : op1;
   assign neg_a  = signed_a(f_q) & a_q[XLEN-1];
   assign neg_b  = signed_b(f_q) & b_q[XLEN-1];
   assign b_mag  = neg_b ? -b_q : b_q;
   assign hi     = acc_q[2*XLEN-1:XLEN];
   assign lo     = acc_q[XLEN-1:0];
   // multiply: multiplier magnitude in low half shifts out as the product shifts in
   assign sum      = {1'b0, hi} + (acc_q[0] ? {1'b0, b_mag} : '0);
   assign mul_step = {sum, acc_q[XLEN-1:1]};
   // divide: partial remainder in high half, quotient bits enter at the bottom
   assign rs       = {hi, acc_q[XLEN-1]};
   assign diff     = rs - {1'b0, b_mag};
   assign div_step = {diff[XLEN] ? rs[XLEN-1:0] : diff[XLEN-1:0], acc_q[XLEN-2:0], ~diff[XLEN]};
   assign div0  = b_q == '0;
   assign ovf   = signed_b(f_q) && a_q == XMIN && b_q == '1;
   assign prod  = (neg_a ^ neg_b) ? -acc_q : acc_q;
   assign q_val = (neg_a ^ neg_b) ? -lo : lo;
   assign r_val = neg_a ? -hi : hi;
   assign fin   = !f_q[2] ? (f_q == F_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                : !f_q[1] ? (div0 ? '1 : ovf ? XMIN : q_val)
                : (div0 ? a_q : ovf ? '0 : r_val);
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      f_d     = f_q;
      a_d     = a_q;
      b_d     = b_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = CALC;
            cnt_d   = '0;
            acc_d   = {{XLEN{1'b0}}, in_mag};
            f_d     = funct3;
            a_d     = op1;
            b_d     = op2;
         end
         CALC: if (f_q[2] && (div0 || ovf)) state_d = DONE;
         else begin
            acc_d   = f_q[2] ? div_step : mul_step;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(XLEN - 1)) ? DONE : CALC;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         f_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         f_q     <= f_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= state_q != IDLE;
         done_q  <= state_q == DONE;
         if (state_q == DONE) res_q <= fin;
      end
   end
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table, corner sequences and random ops against a plain-arithmetic model
module tb_muldiv_unit;
   logic        clk = 0, reset = 1, start = 0;
   logic [2:0]  funct3 = 0;
   logic [31:0] op1 = 0, op2 = 0, result;
   logic        busy, done;
   int          checks = 0, failures = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .start(start), .funct3(funct3),
      .op1(op1), .op2(op2), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a, b, exp;
      int          lat;
   } vec_t;
   vec_t vecs[14];

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      logic [63:0] p;
      logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_done(output int n, output bit busy_bad);
      n = 0;
      busy_bad = 0;
      while (!done && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (!busy) busy_bad = 1;
      end
   endtask

   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string nm);
      int n;
      bit bb;
      @(negedge clk);
      start = 1; funct3 = f; op1 = a; op2 = b;
      @(posedge clk);
      #1 start = 0; op1 = ~a; op2 = ~b; funct3 = ~f;
      wait_done(n, bb);
      chk({nm, " latency"}, 64'(n), 64'(lat));
      chk({nm, " result"}, 64'(result), 64'(exp));
      chk({nm, " busy"}, 64'(bb), 0);
      @(posedge clk);
      #1 chk({nm, " idle"}, {62'b0, busy, done}, 0);
   endtask

   initial begin
      int n, pulses;
      bit bb;
      logic [2:0] f;
      logic [31:0] a, b;
      vecs[0]  = '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
      vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
      vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
      vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33};
      vecs[6]  = '{3'd5, 32'd100, 32'd7, 32'd14, 33};
      vecs[7]  = '{3'd7, 32'd100, 32'd7, 32'd2, 33};
      vecs[8]  = '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2};
      vecs[9]  = '{3'd6, 32'd5, 32'd0, 32'd5, 2};
      vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
      vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2};
      vecs[12] = '{3'd7, 32'd9, 32'd0, 32'd9, 2};
      vecs[13] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33};
      repeat (3) @(posedge clk);
      #1 chk("reset state", {31'b0, busy, done, result}, 0);
      @(negedge clk) reset = 0;
      foreach (vecs[i])
         do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
      // start pulsed mid-operation is ignored; start during the done cycle is accepted
      @(negedge clk);
      start = 1; funct3 = 3'd0; op1 = 3; op2 = 5;
      @(posedge clk);
      #1 start = 0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      start = 1; funct3 = 3'd3; op1 = 100; op2 = 100;
      @(posedge clk);
      #1 start = 0;
      wait_done(n, bb);
      chk("ignored start latency", 64'(n + 10), 33);
      chk("ignored start result", 64'(result), 15);
      start = 1; funct3 = 3'd0; op1 = 6; op2 = 7;
      @(posedge clk);
      #1 start = 0;
      chk("result held", 64'(result), 15);
      wait_done(n, bb);
      chk("back-to-back latency", 64'(n), 33);
      chk("back-to-back result", 64'(result), 42);
      @(posedge clk);
      #1;
      // reset in the middle of a divide aborts it silently
      @(negedge clk);
      start = 1; funct3 = 3'd4; op1 = 1000; op2 = 3;
      @(posedge clk);
      #1 start = 0;
      repeat (14) @(posedge clk);
      @(negedge clk) reset = 1;
      @(posedge clk);
      #1 chk("abort state", {31'b0, busy, done, result}, 0);
      @(negedge clk) reset = 0;
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1 if (done || busy) pulses++;
      end
      chk("abort no done", 64'(pulses), 0);
      do_op(3'd4, 1000, 3, 333, 33, "after abort");
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 15);
            3: a = 32'h8000_0000;
            default: ;
         endcase
         do_op(f, a, b, model(f, a, b),
               (f[2] && (b == 0 || (f inside {3'd4, 3'd6} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 2 : 33,
               $sformatf("rand%0d f=%0d a=%h b=%h", i, f, a, b));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
